// File: rtl/stream_narrow_bp_if.sv
// rtl/stream_narrow_bp_if.sv - wide-in / narrow-out stream bundle for stream_narrow_bp
interface stream_narrow_bp_if #(
  parameter int STREAM_WIDTH         = 8,
  parameter int STREAM_IN_MULTIPLIER = 3,
  parameter int STREAM_IN_WIDTH      = STREAM_WIDTH * STREAM_IN_MULTIPLIER,
  parameter int LANE_W               = $clog2(STREAM_IN_MULTIPLIER + 1)
);
  logic [STREAM_IN_WIDTH-1:0] stream_in;
  logic                       stream_in_valid;
  logic                       stream_in_first;
  logic                       stream_in_last;
  logic [LANE_W-1:0]          stream_in_lanes;
  logic                       stream_in_ready;
  logic [STREAM_WIDTH-1:0]    stream_out;
  logic                       stream_out_valid;
  logic                       stream_out_first;
  logic                       stream_out_last;
  logic                       stream_out_ready;

  // Producer/consumer side (drives wide words, accepts narrow beats)
  modport master (
    output stream_in, stream_in_valid, stream_in_first, stream_in_last, stream_in_lanes,
    input  stream_in_ready,
    input  stream_out, stream_out_valid, stream_out_first, stream_out_last,
    output stream_out_ready
  );

  // Converter side
  modport slave (
    input  stream_in, stream_in_valid, stream_in_first, stream_in_last, stream_in_lanes,
    output stream_in_ready,
    output stream_out, stream_out_valid, stream_out_first, stream_out_last,
    input  stream_out_ready
  );
endinterface

// File: rtl/stream_narrow_bp.sv
// rtl/stream_narrow_bp.sv - buffered wide-to-narrow converter with backpressure; option macro STREAM_NARROW_MSB_FIRST_EN
module stream_narrow_bp #(
  parameter int STREAM_WIDTH         = 8,
  parameter int STREAM_IN_MULTIPLIER = 3,
  parameter int BUFFER_DEPTH         = 9,
  parameter int BUFFER_ACCEPT_SPACE  = 64,
  parameter int STREAM_IN_WIDTH      = STREAM_WIDTH * STREAM_IN_MULTIPLIER,
  parameter int LANE_W               = $clog2(STREAM_IN_MULTIPLIER + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  stream_narrow_bp_if.slave     bus,
  output logic [BUFFER_DEPTH:0] fifo_level,
  output logic                  overflow
);

  localparam int LVL_W   = BUFFER_DEPTH + 1;
  localparam int ENTRY_W = STREAM_IN_WIDTH + 2 + LANE_W;
  localparam logic [LVL_W-1:0]  FULL    = LVL_W'(1) << BUFFER_DEPTH;
  localparam logic [LANE_W-1:0] LANES_M = LANE_W'(STREAM_IN_MULTIPLIER);

  // FIFO storage: entry = {lanes, first, last, data}
  logic [ENTRY_W-1:0]         r_mem [2**BUFFER_DEPTH];
  logic [BUFFER_DEPTH-1:0]    r_wr_ptr;
  logic [BUFFER_DEPTH-1:0]    r_rd_ptr;
  logic [LVL_W-1:0]           r_level;
  logic                       r_overflow;
  logic                       r_in_ready;

  // Prefetch stage: next word waiting for the serializer
  logic                       r_p_valid;
  logic [ENTRY_W-1:0]         r_p_entry;

  // Serializer stage: word being split plus lane index
  logic                       r_s_valid;
  logic [STREAM_IN_WIDTH-1:0] r_s_data;
  logic                       r_s_first;
  logic                       r_s_last;
  logic [LANE_W-1:0]          r_s_lanes;
  logic [LANE_W-1:0]          r_s_idx;

  // Output beat register
  logic                       r_o_valid;
  logic [STREAM_WIDTH-1:0]    r_o_data;
  logic                       r_o_first;
  logic                       r_o_last;

  logic                       w_full;
  logic                       w_empty;
  logic                       w_wr;
  logic [LANE_W-1:0]          w_lanes_norm;
  logic                       w_o_take;
  logic                       w_s_push;
  logic                       w_s_end;
  logic                       w_s_done;
  logic                       w_s_load;
  logic                       w_p_load;
  logic [LVL_W-1:0]           w_level_next;
  logic [LVL_W-1:0]           w_free;
  logic [31:0]                w_free32;
  logic [LANE_W-1:0]          w_phys;
  logic [STREAM_WIDTH-1:0]    w_lane_data;

  // Full uses the registered level, so a same-cycle read never rescues a write
  assign w_full       = (r_level == FULL);
  assign w_empty      = (r_level == '0);
  assign w_wr         = bus.stream_in_valid & ~w_full;
  assign w_lanes_norm = ((bus.stream_in_lanes == '0) || (bus.stream_in_lanes > LANES_M))
                        ? LANES_M : bus.stream_in_lanes;

  // Elastic chain FIFO -> prefetch -> serializer -> output register; ready flows back combinationally
  assign w_o_take = ~r_o_valid | bus.stream_out_ready;
  assign w_s_push = r_s_valid & w_o_take;
  assign w_s_end  = (r_s_idx == (r_s_lanes - LANE_W'(1)));
  assign w_s_done = w_s_push & w_s_end;
  assign w_s_load = r_p_valid & (~r_s_valid | w_s_done);
  assign w_p_load = ~w_empty & (~r_p_valid | w_s_load);

  assign w_level_next = r_level + LVL_W'(w_wr) - LVL_W'(w_p_load);
  assign w_free       = FULL - w_level_next;
  assign w_free32     = 32'(w_free);

`ifdef STREAM_NARROW_MSB_FIRST_EN
  assign w_phys = LANES_M - LANE_W'(1) - r_s_idx;
`else
  assign w_phys = r_s_idx;
`endif

  // Select the physical lane addressed by the current lane index
  always_comb begin
    w_lane_data = '0;
    for (int i = 0; i < STREAM_IN_MULTIPLIER; i++) begin
      if (w_phys == LANE_W'(i)) w_lane_data = r_s_data[i*STREAM_WIDTH +: STREAM_WIDTH];
    end
  end

  // Memory write port; contents survive reset
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= {w_lanes_norm, bus.stream_in_first, bus.stream_in_last, bus.stream_in};
  end

  // FIFO pointers, level, sticky overflow and registered credit flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
      r_in_ready <= 1'b0;
    end else begin
      if (w_wr)     r_wr_ptr <= r_wr_ptr + BUFFER_DEPTH'(1);
      if (w_p_load) r_rd_ptr <= r_rd_ptr + BUFFER_DEPTH'(1);
      if (bus.stream_in_valid && w_full) r_overflow <= 1'b1;
      r_level    <= w_level_next;
      r_in_ready <= (w_free32 > 32'(BUFFER_ACCEPT_SPACE));
    end
  end

  // Prefetch register keeps the next word ready so words chain without a bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p_valid <= 1'b0;
      r_p_entry <= '0;
    end else if (w_p_load) begin
      r_p_valid <= 1'b1;
      r_p_entry <= r_mem[r_rd_ptr];
    end else if (w_s_load) begin
      r_p_valid <= 1'b0;
    end
  end

  // Serializer: load a word, step the lane index on each beat handed to the output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s_valid <= 1'b0;
      r_s_data  <= '0;
      r_s_first <= 1'b0;
      r_s_last  <= 1'b0;
      r_s_lanes <= '0;
      r_s_idx   <= '0;
    end else if (w_s_load) begin
      r_s_valid <= 1'b1;
      r_s_data  <= r_p_entry[STREAM_IN_WIDTH-1:0];
      r_s_last  <= r_p_entry[STREAM_IN_WIDTH];
      r_s_first <= r_p_entry[STREAM_IN_WIDTH+1];
      r_s_lanes <= r_p_entry[ENTRY_W-1 -: LANE_W];
      r_s_idx   <= '0;
    end else if (w_s_done) begin
      r_s_valid <= 1'b0;
    end else if (w_s_push) begin
      r_s_idx   <= r_s_idx + LANE_W'(1);
    end
  end

  // Output beat register; held stable while valid and not accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_o_valid <= 1'b0;
      r_o_data  <= '0;
      r_o_first <= 1'b0;
      r_o_last  <= 1'b0;
    end else if (w_o_take) begin
      r_o_valid <= r_s_valid;
      if (r_s_valid) begin
        r_o_data  <= w_lane_data;
        r_o_first <= r_s_first & (r_s_idx == '0);
        r_o_last  <= r_s_last & w_s_end;
      end
    end
  end

  assign bus.stream_in_ready  = r_in_ready;
  assign bus.stream_out       = r_o_data;
  assign bus.stream_out_valid = r_o_valid;
  assign bus.stream_out_first = r_o_first;
  assign bus.stream_out_last  = r_o_last;
  assign fifo_level           = r_level;
  assign overflow             = r_overflow;

endmodule

// File: tb/tb_stream_narrow_bp.sv
// tb/tb_stream_narrow_bp.sv - self-checking bench for stream_narrow_bp (M=3, W=8, DEPTH=4, ACCEPT=4)
module tb_stream_narrow_bp;

  logic       clk;
  logic       rst_n;
  logic [4:0] fifo_level;
  logic       overflow;
  logic       rdy;

  stream_narrow_bp_if #(.STREAM_WIDTH(8), .STREAM_IN_MULTIPLIER(3)) bus ();

  stream_narrow_bp #(
    .STREAM_WIDTH(8), .STREAM_IN_MULTIPLIER(3), .BUFFER_DEPTH(4), .BUFFER_ACCEPT_SPACE(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .fifo_level(fifo_level), .overflow(overflow)
  );

  assign bus.stream_out_ready = rdy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic       f;
    logic       l;
  } beat_t;

  typedef struct {
    logic [23:0] data;
    logic        first;
    logic        last;
    logic [1:0]  lanes;
    int          n;
    logic [7:0]  e0, e1, e2;
  } vec_t;

  beat_t exp_q[$];
  int    xq[$];
  int    n_checks = 0;
  int    n_pass   = 0;
  int    cyc      = 0;
  logic  prev_hold = 1'b0;
  beat_t prev_beat;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [23:0] d, input logic f, input logic l, input logic [1:0] ln);
    bus.stream_in       = d;
    bus.stream_in_first = f;
    bus.stream_in_last  = l;
    bus.stream_in_lanes = ln;
    bus.stream_in_valid = 1'b1;
    tick();
    bus.stream_in_valid = 1'b0;
  endtask

  // Reference lane ordering for generated words
  task automatic expect_word(input logic [23:0] d, input logic f, input logic l, input logic [1:0] ln);
    int n;
    n = (ln == 2'd0) ? 3 : int'(ln);
    for (int k = 0; k < n; k++) begin
      int p;
`ifdef STREAM_NARROW_MSB_FIRST_EN
      p = 2 - k;
`else
      p = k;
`endif
      exp_q.push_back('{d: d[p*8 +: 8], f: (f && k == 0), l: (l && k == n - 1)});
    end
  endtask

  task automatic drain(input string name);
    int g;
    g = 0;
    rdy = 1'b1;
    while ((exp_q.size() != 0 || bus.stream_out_valid) && g < 300) begin
      tick();
      g++;
    end
    chk(name, 32'(g < 300), 32'd1);
  endtask

  // Scoreboard, hold-stability and level-bound monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (rst_n) begin
      beat_t cur;
      cur = '{d: bus.stream_out, f: bus.stream_out_first, l: bus.stream_out_last};
      if (prev_hold) begin
        chk("hold_valid", 32'(bus.stream_out_valid), 32'd1);
        chk("hold_beat", 32'(cur), 32'(prev_beat));
      end
      chk("level_bound", 32'(fifo_level <= 5'd16), 32'd1);
      if (bus.stream_out_valid && rdy) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 32'(cur), 32'hFFFFFFFF);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          chk("beat", 32'(cur), 32'(e));
        end
        xq.push_back(cyc);
      end
      prev_hold = bus.stream_out_valid & ~rdy;
      prev_beat = cur;
    end else begin
      prev_hold = 1'b0;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  vec_t vt[5];

  initial begin
    int n0;
    int sent;
    int guard;
`ifdef STREAM_NARROW_MSB_FIRST_EN
    vt[0] = '{data: 24'h665544, first: 1, last: 0, lanes: 3, n: 3, e0: 8'h66, e1: 8'h55, e2: 8'h44};
    vt[1] = '{data: 24'hCCBB00, first: 0, last: 1, lanes: 2, n: 2, e0: 8'hCC, e1: 8'hBB, e2: 8'h00};
    vt[2] = '{data: 24'hC70000, first: 1, last: 1, lanes: 1, n: 1, e0: 8'hC7, e1: 8'h00, e2: 8'h00};
    vt[3] = '{data: 24'hEEDDCC, first: 1, last: 0, lanes: 0, n: 3, e0: 8'hEE, e1: 8'hDD, e2: 8'hCC};
    vt[4] = '{data: 24'h999897, first: 0, last: 1, lanes: 3, n: 3, e0: 8'h99, e1: 8'h98, e2: 8'h97};
`else
    vt[0] = '{data: 24'h665544, first: 1, last: 0, lanes: 3, n: 3, e0: 8'h44, e1: 8'h55, e2: 8'h66};
    vt[1] = '{data: 24'h00BBAA, first: 0, last: 1, lanes: 2, n: 2, e0: 8'hAA, e1: 8'hBB, e2: 8'h00};
    vt[2] = '{data: 24'h0000C7, first: 1, last: 1, lanes: 1, n: 1, e0: 8'hC7, e1: 8'h00, e2: 8'h00};
    vt[3] = '{data: 24'hEEDDCC, first: 1, last: 0, lanes: 0, n: 3, e0: 8'hCC, e1: 8'hDD, e2: 8'hEE};
    vt[4] = '{data: 24'h999897, first: 0, last: 1, lanes: 3, n: 3, e0: 8'h97, e1: 8'h98, e2: 8'h99};
`endif

    rst_n = 1'b0;
    rdy   = 1'b0;
    bus.stream_in       = '0;
    bus.stream_in_valid = 1'b0;
    bus.stream_in_first = 1'b0;
    bus.stream_in_last  = 1'b0;
    bus.stream_in_lanes = '0;

    // Reset state
    #3;
    chk("rst_in_ready", 32'(bus.stream_in_ready), 32'd0);
    chk("rst_out_valid", 32'(bus.stream_out_valid), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    chk("in_ready_before_edge", 32'(bus.stream_in_ready), 32'd0);
    tick();
    chk("in_ready_after_edge", 32'(bus.stream_in_ready), 32'd1);

    // Single word: exact 3-edge latency then consecutive beats
    rdy = 1'b1;
    expect_word(24'h332211, 1'b1, 1'b1, 2'd3);
    put(24'h332211, 1'b1, 1'b1, 2'd3);
    tick();
    chk("lat_n1", 32'(bus.stream_out_valid), 32'd0);
    tick();
    chk("lat_n2", 32'(bus.stream_out_valid), 32'd0);
    tick();
    chk("lat_n3", 32'(bus.stream_out_valid), 32'd1);
`ifdef STREAM_NARROW_MSB_FIRST_EN
    chk("lat_data", 32'(bus.stream_out), 32'h33);
`else
    chk("lat_data", 32'(bus.stream_out), 32'h11);
`endif
    chk("lat_first", 32'(bus.stream_out_first), 32'd1);
    chk("lat_last", 32'(bus.stream_out_last), 32'd0);
    drain("drain_single");
    chk("single_valid_low", 32'(bus.stream_out_valid), 32'd0);

    // Table-driven back-to-back words with hand-computed beats
    n0 = xq.size();
    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < vt[i].n; k++) begin
        logic [7:0] e;
        e = (k == 0) ? vt[i].e0 : (k == 1) ? vt[i].e1 : vt[i].e2;
        exp_q.push_back('{d: e, f: (vt[i].first && k == 0), l: (vt[i].last && k == vt[i].n - 1)});
      end
    end
    for (int i = 0; i < 5; i++) put(vt[i].data, vt[i].first, vt[i].last, vt[i].lanes);
    drain("drain_table");
    chk("table_beats", 32'(xq.size() - n0), 32'd12);
    if (xq.size() - n0 == 12) chk("table_no_gap", 32'(xq[xq.size()-1] - xq[n0] + 1), 32'd12);

    // Random words, random lanes, 50% ready
    sent  = 0;
    guard = 0;
    while ((sent < 100 || exp_q.size() != 0 || bus.stream_out_valid) && guard < 5000) begin
      if (sent < 100 && bus.stream_in_ready && $urandom_range(0, 1) == 1) begin
        bus.stream_in       = 24'($urandom);
        bus.stream_in_first = 1'($urandom_range(0, 1));
        bus.stream_in_last  = 1'($urandom_range(0, 1));
        bus.stream_in_lanes = 2'($urandom_range(0, 3));
        bus.stream_in_valid = 1'b1;
        expect_word(bus.stream_in, bus.stream_in_first, bus.stream_in_last, bus.stream_in_lanes);
        sent++;
      end else begin
        bus.stream_in_valid = 1'b0;
      end
      rdy = 1'($urandom_range(0, 1));
      tick();
      guard++;
    end
    bus.stream_in_valid = 1'b0;
    chk("random_done", 32'(guard < 5000), 32'd1);

    // Fill with ready low: two words sit in the pipeline, then 16 fill the FIFO, 17th dropped
    rdy = 1'b0;
    expect_word(24'hA2A1A0, 1'b0, 1'b0, 2'd3);
    expect_word(24'hB2B1B0, 1'b0, 1'b0, 2'd3);
    put(24'hA2A1A0, 1'b0, 1'b0, 2'd3);
    put(24'hB2B1B0, 1'b0, 1'b0, 2'd3);
    repeat (4) tick();
    chk("fill_level0", 32'(fifo_level), 32'd0);
    for (int k = 1; k <= 17; k++) begin
      logic [23:0] d;
      d = {8'(8'h30 + k), 8'(8'h20 + k), 8'(8'h10 + k)};
      if (k <= 16) expect_word(d, 1'b0, 1'b0, 2'd3);
      put(d, 1'b0, 1'b0, 2'd3);
      if (k == 11) chk("in_ready_free5", 32'(bus.stream_in_ready), 32'd1);
      if (k == 12) chk("in_ready_free4", 32'(bus.stream_in_ready), 32'd0);
      if (k == 16) begin
        chk("ovf_before_drop", 32'(overflow), 32'd0);
        chk("level_full", 32'(fifo_level), 32'd16);
      end
      if (k == 17) begin
        chk("ovf_after_drop", 32'(overflow), 32'd1);
        chk("level_after_drop", 32'(fifo_level), 32'd16);
      end
    end
    drain("drain_full");
    chk("ovf_sticky", 32'(overflow), 32'd1);
    chk("level_empty", 32'(fifo_level), 32'd0);

    // Asynchronous reset mid-burst
    rdy = 1'b0;
    for (int k = 0; k < 7; k++) put({8'(8'h70 + k), 8'(8'h60 + k), 8'(8'h50 + k)}, 1'b0, 1'b0, 2'd3);
    chk("mid_level5", 32'(fifo_level), 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_level", 32'(fifo_level), 32'd0);
    chk("async_valid", 32'(bus.stream_out_valid), 32'd0);
    chk("async_in_ready", 32'(bus.stream_in_ready), 32'd0);
    chk("async_overflow", 32'(overflow), 32'd0);
    chk("async_flags", 32'({bus.stream_out, bus.stream_out_first, bus.stream_out_last}), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_in_ready", 32'(bus.stream_in_ready), 32'd1);
    rdy = 1'b1;
    expect_word(24'h030201, 1'b1, 1'b1, 2'd3);
    put(24'h030201, 1'b1, 1'b1, 2'd3);
    drain("drain_post_reset");

`ifdef STREAM_NARROW_MSB_FIRST_EN
    // Partial word sits in the top lanes
    expect_word(24'hCCBB00, 1'b1, 1'b1, 2'd2);
    put(24'hCCBB00, 1'b1, 1'b1, 2'd2);
    drain("drain_msb_partial");
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
